knight_scan: RTL

KNIGHT_SCAN -- requirements
Module: knight_scan

---
 rtl/knight_scan.sv | 118 +++++++++++
 1 files changed

// File: rtl/knight_scan.sv
// rtl/knight_scan.sv - bouncing/wrapping single-LED scanner with prescaler
// Optional trail LED (previous position) enabled by defining KNIGHT_SCAN_TRAIL_EN.
module knight_scan #(
  parameter int N     = 8,
  parameter int DIV_W = 8
) (
  input  logic                 ck,
  input  logic                 res,
  input  logic                 en,
  input  logic [DIV_W-1:0]     div,
  input  logic [1:0]           mode,
  output logic [N-1:0]         out,
  output logic [$clog2(N)-1:0] pos,
  output logic                 dir,
  output logic                 step
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [N-1:0]  BIT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    M_BOUNCE  = 2'b00,
    M_WRAP_UP = 2'b01,
    M_WRAP_DN = 2'b10,
    M_HOLD    = 2'b11
  } mode_t;

  logic [DIV_W-1:0] r_cnt;
  logic [PW-1:0]    r_pos;
  logic             r_dir;
  logic [N-1:0]     r_out;
  logic             r_step;

  mode_t            w_mode;
  logic             w_tick;
  logic             w_move;
  logic [PW-1:0]    w_pos_nx;
  logic             w_dir_nx;
  logic [N-1:0]     w_out_nx;

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] p);
    return BIT0 << p;
  endfunction

  assign w_mode = mode_t'(mode);
  // >= rather than == so a lowered div never forces a wrap through 2^DIV_W
  assign w_tick = en && (r_cnt >= div);
  assign w_move = w_tick && (w_mode != M_HOLD);

  always_comb begin
    w_pos_nx = r_pos;
    w_dir_nx = r_dir;
    if (w_move) begin
      unique case (w_mode)
        M_BOUNCE: begin
          if (r_dir) begin
            if (r_pos == LAST) w_dir_nx = 1'b0;
            else               w_pos_nx = r_pos + PW'(1);
          end else begin
            if (r_pos == '0)   w_dir_nx = 1'b1;
            else               w_pos_nx = r_pos - PW'(1);
          end
        end
        M_WRAP_UP: begin
          w_dir_nx = 1'b1;
          w_pos_nx = (r_pos == LAST) ? '0 : r_pos + PW'(1);
        end
        M_WRAP_DN: begin
          w_dir_nx = 1'b0;
          w_pos_nx = (r_pos == '0) ? LAST : r_pos - PW'(1);
        end
        default: begin
          w_pos_nx = r_pos;
          w_dir_nx = r_dir;
        end
      endcase
    end
  end

`ifdef KNIGHT_SCAN_TRAIL_EN
  logic [PW-1:0] r_prv;
  logic [PW-1:0] w_prv_nx;

  assign w_prv_nx = w_move ? r_pos : r_prv;
  assign w_out_nx = onehot(w_pos_nx) | onehot(w_prv_nx);

  always_ff @(posedge ck or posedge res) begin
    if (res) r_prv <= '0;
    else     r_prv <= w_prv_nx;
  end
`else
  assign w_out_nx = onehot(w_pos_nx);
`endif

  // out is decoded from next state so it lands on the same edge as pos
  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      r_cnt  <= '0;
      r_pos  <= '0;
      r_dir  <= 1'b1;
      r_out  <= BIT0;
      r_step <= 1'b0;
    end else begin
      if (en) r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
      r_pos  <= w_pos_nx;
      r_dir  <= w_dir_nx;
      r_out  <= w_out_nx;
      r_step <= w_move;
    end
  end

  assign out  = r_out;
  assign pos  = r_pos;
  assign dir  = r_dir;
  assign step = r_step;

endmodule
